// File: rtl/hwpe_stream_package.sv
// -----------------------------------------------------------------------------
// hwpe_stream_package
// Shared types for the HWPE stream copy network.
//   copy_fault_t      : per-cycle fault cause, {protocol, ready_mismatch}
//   copy_src_state_e  : state of the producer-side stall checker
// -----------------------------------------------------------------------------
package hwpe_stream_package;

    typedef struct packed {
        logic protocol;
        logic ready_mismatch;
    } copy_fault_t;

    typedef enum logic [0:0] {
        CS_IDLE  = 1'b0,
        CS_STALL = 1'b1
    } copy_src_state_e;

endpackage

// File: rtl/hwpe_stream_stall_checker.sv
// -----------------------------------------------------------------------------
// hwpe_stream_stall_checker
// Watches a stream producer and flags protocol violations while a beat is
// stalled (valid high, ready low): valid must stay high and data/strb must
// stay stable until the handshake completes.
//
// Ports
//   clk_i, rst_i       clock, synchronous active-high reset
//   valid_i, ready_i   observed handshake of the normal stream
//   data_i, strb_i     observed payload of the normal stream
//   protocol_fault_o   combinational raw fault for the current cycle
//   state_o            debug view of the FSM (1 = STALL)
// -----------------------------------------------------------------------------
module hwpe_stream_stall_checker
    import hwpe_stream_package::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    valid_i,
    input  logic                    ready_i,
    input  logic [DATA_WIDTH-1:0]   data_i,
    input  logic [DATA_WIDTH/8-1:0] strb_i,
    output logic                    protocol_fault_o,
    output logic                    state_o
);

    copy_src_state_e         state_q, state_d;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [DATA_WIDTH/8-1:0] strb_q;
    logic                    capture_en;

    always_comb begin
        state_d          = state_q;
        capture_en       = 1'b0;
        protocol_fault_o = 1'b0;
        case (state_q)
            CS_IDLE: begin
                if (valid_i && !ready_i) begin
                    capture_en = 1'b1;
                    state_d    = CS_STALL;
                end
            end
            CS_STALL: begin
                if (!valid_i) begin
                    // valid withdrawn before the handshake
                    protocol_fault_o = 1'b1;
                    state_d          = CS_IDLE;
                end else begin
                    // Re-capture on corruption so a single change is
                    // reported once, not on every following cycle.
                    if ((data_i != data_q) || (strb_i != strb_q)) begin
                        protocol_fault_o = 1'b1;
                        capture_en       = 1'b1;
                    end
                    if (ready_i) begin
                        state_d = CS_IDLE;
                    end
                end
            end
            default: state_d = CS_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= CS_IDLE;
            data_q  <= '0;
            strb_q  <= '0;
        end else begin
            state_q <= state_d;
            if (capture_en) begin
                data_q <= data_i;
                strb_q <= strb_i;
            end
        end
    end

    assign state_o = (state_q == CS_STALL);

endmodule

// File: rtl/hwpe_stream_copy_source.sv
// -----------------------------------------------------------------------------
// hwpe_stream_copy_source
// Head end of the stream copy network. Mirrors the normal stream onto the
// copy stream with zero latency and checks the returning copy ready against
// the normal ready every cycle. Faults are registered (one cycle latency),
// sticky and counted with a saturating counter.
//
// Optional feature (macro HWPE_STREAM_COPY_SOURCE_PROTOCOL_CHECK_EN):
//   adds hwpe_stream_stall_checker, which enforces valid/data stability on
//   the normal producer during stalls; reported on fault_type_o[1].
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   normal_valid_i/ready_i/data_i/strb_i  normal stream, observed only
//   copy_valid_o/data_o/strb_o   regenerated copy stream
//   copy_ready_i                 ready returning from the copy sink
//   clear_fault_i                clears sticky flag and counter
//   fault_detected_o             one-cycle pulse per faulty cycle
//   fault_sticky_o               set on any fault until clear/reset
//   fault_type_o                 cause of last fault {protocol, ready_mismatch}
//   fault_cnt_o                  saturating count of faulty cycles
//
// Handshake: a beat transfers in a cycle where valid and ready are both
// high; once valid is raised it stays high with stable data/strb until then.
// -----------------------------------------------------------------------------
module hwpe_stream_copy_source
    import hwpe_stream_package::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    normal_valid_i,
    input  logic                    normal_ready_i,
    input  logic [DATA_WIDTH-1:0]   normal_data_i,
    input  logic [DATA_WIDTH/8-1:0] normal_strb_i,
    output logic                    copy_valid_o,
    input  logic                    copy_ready_i,
    output logic [DATA_WIDTH-1:0]   copy_data_o,
    output logic [DATA_WIDTH/8-1:0] copy_strb_o,
    input  logic                    clear_fault_i,
    output logic                    fault_detected_o,
    output logic                    fault_sticky_o,
    output logic [1:0]              fault_type_o,
    output logic [CNT_WIDTH-1:0]    fault_cnt_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    copy_fault_t fault_raw;
    copy_fault_t fault_type_q;
    logic        fault_any;
    logic        fault_detected_q;
    logic        fault_sticky_q;
    logic [CNT_WIDTH-1:0] fault_cnt_q;

    assign copy_valid_o = normal_valid_i;
    assign copy_data_o  = normal_data_i;
    assign copy_strb_o  = normal_strb_i;

    // Ready comparison is independent of valid.
    assign fault_raw.ready_mismatch = (copy_ready_i != normal_ready_i);

`ifdef HWPE_STREAM_COPY_SOURCE_PROTOCOL_CHECK_EN
    logic stall_state;

    hwpe_stream_stall_checker #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_stall_checker (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .valid_i          (normal_valid_i),
        .ready_i          (normal_ready_i),
        .data_i           (normal_data_i),
        .strb_i           (normal_strb_i),
        .protocol_fault_o (fault_raw.protocol),
        .state_o          (stall_state)
    );
`else
    assign fault_raw.protocol = 1'b0;
`endif

    assign fault_any = fault_raw.protocol | fault_raw.ready_mismatch;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fault_detected_q <= 1'b0;
            fault_type_q     <= '0;
            fault_sticky_q   <= 1'b0;
            fault_cnt_q      <= '0;
        end else begin
            fault_detected_q <= fault_any;
            if (fault_any) begin
                fault_type_q   <= fault_raw;
                fault_sticky_q <= 1'b1;
                // A fresh fault beats a simultaneous clear.
                if (clear_fault_i) begin
                    fault_cnt_q <= {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                end else if (fault_cnt_q != CNT_MAX) begin
                    fault_cnt_q <= fault_cnt_q + 1'b1;
                end
            end else if (clear_fault_i) begin
                fault_sticky_q <= 1'b0;
                fault_cnt_q    <= '0;
            end
        end
    end

    assign fault_detected_o = fault_detected_q;
    assign fault_sticky_o   = fault_sticky_q;
    assign fault_type_o     = fault_type_q;
    assign fault_cnt_o      = fault_cnt_q;

endmodule

// File: tb/tb_hwpe_stream_copy_source.sv
// -----------------------------------------------------------------------------
// tb_hwpe_stream_copy_source
// Two instances share one stimulus: dut (CNT_WIDTH=8) and dut_s (CNT_WIDTH=2)
// so counter saturation is observable alongside the default build.
// Define HWPE_STREAM_COPY_SOURCE_PROTOCOL_CHECK_EN to exercise the protocol
// checker scenarios as well.
// -----------------------------------------------------------------------------
module tb_hwpe_stream_copy_source;

    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          n_valid, n_ready, c_ready, clr;
    logic [DW-1:0] n_data;
    logic [SW-1:0] n_strb;

    logic          a_cvalid, b_cvalid;
    logic [DW-1:0] a_cdata, b_cdata;
    logic [SW-1:0] a_cstrb, b_cstrb;
    logic          a_det, a_sticky, b_det, b_sticky;
    logic [1:0]    a_type, b_type;
    logic [7:0]    a_cnt;
    logic [1:0]    b_cnt;

    always #5 clk = ~clk;

    hwpe_stream_copy_source #(.DATA_WIDTH(DW), .CNT_WIDTH(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .normal_valid_i(n_valid), .normal_ready_i(n_ready),
        .normal_data_i(n_data), .normal_strb_i(n_strb),
        .copy_valid_o(a_cvalid), .copy_ready_i(c_ready),
        .copy_data_o(a_cdata), .copy_strb_o(a_cstrb),
        .clear_fault_i(clr),
        .fault_detected_o(a_det), .fault_sticky_o(a_sticky),
        .fault_type_o(a_type), .fault_cnt_o(a_cnt)
    );

    hwpe_stream_copy_source #(.DATA_WIDTH(DW), .CNT_WIDTH(2)) dut_s (
        .clk_i(clk), .rst_i(rst),
        .normal_valid_i(n_valid), .normal_ready_i(n_ready),
        .normal_data_i(n_data), .normal_strb_i(n_strb),
        .copy_valid_o(b_cvalid), .copy_ready_i(c_ready),
        .copy_data_o(b_cdata), .copy_strb_o(b_cstrb),
        .clear_fault_i(clr),
        .fault_detected_o(b_det), .fault_sticky_o(b_sticky),
        .fault_type_o(b_type), .fault_cnt_o(b_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: outputs expected after the most recent edge.
    logic          m_det, m_sticky;
    logic [1:0]    m_type;
    int            m_cnt, m_cnt_s;
    logic          m_pend;
    logic [DW-1:0] m_pdata;
    logic [SW-1:0] m_pstrb;
    logic [DW-1:0] exp_q[$];

    // Applies one clock edge of the rules to the inputs present at that edge.
    task automatic model_edge();
        logic rm, pf, any;
        if (rst) begin
            m_det = 0; m_sticky = 0; m_type = 0; m_cnt = 0; m_cnt_s = 0;
            m_pend = 0; m_pdata = 0; m_pstrb = 0;
            return;
        end
        rm = (c_ready != n_ready);
        pf = 1'b0;
`ifdef HWPE_STREAM_COPY_SOURCE_PROTOCOL_CHECK_EN
        // A beat offered but not taken must be offered unchanged next cycle.
        if (m_pend) begin
            if (!n_valid) begin
                pf = 1'b1;
                m_pend = 1'b0;
            end else begin
                if (n_data !== m_pdata || n_strb !== m_pstrb) pf = 1'b1;
                m_pdata = n_data;
                m_pstrb = n_strb;
                if (n_ready) m_pend = 1'b0;
            end
        end else if (n_valid && !n_ready) begin
            m_pend = 1'b1;
            m_pdata = n_data;
            m_pstrb = n_strb;
        end
`endif
        any = rm | pf;
        m_det = any;
        if (any) begin
            m_type   = {pf, rm};
            m_sticky = 1'b1;
            m_cnt    = clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
            m_cnt_s  = clr ? 1 : ((m_cnt_s < 3) ? m_cnt_s + 1 : 3);
        end else if (clr) begin
            m_sticky = 1'b0;
            m_cnt = 0;
            m_cnt_s = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        n_valid = 0; n_ready = 1; c_ready = 1; clr = 0;
        n_data = '0; n_strb = '0;
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        step();
        step();
        n_cmp++; if (a_det !== 1'b0)    begin n_err++; $display("FAIL reset_det got %b want 0", a_det); end
        n_cmp++; if (a_sticky !== 1'b0) begin n_err++; $display("FAIL reset_sticky got %b want 0", a_sticky); end
        n_cmp++; if (a_type !== 2'b00)  begin n_err++; $display("FAIL reset_type got %b want 00", a_type); end
        n_cmp++; if (a_cnt !== 8'd0)    begin n_err++; $display("FAIL reset_cnt got %0d want 0", a_cnt); end
        n_cmp++; if ({b_det, b_sticky, b_type, b_cnt} !== 6'd0)
            begin n_err++; $display("FAIL reset_sat got %b want 000000", {b_det, b_sticky, b_type, b_cnt}); end
        n_cmp++; if (a_cvalid !== 1'b0) begin n_err++; $display("FAIL reset_cvalid got %b want 0", a_cvalid); end
        rst = 0;
    endtask

    task automatic test_stream();
        int beat = 1;
        int cycles = 0;
        logic [DW-1:0] e;
        n_strb = SW'($urandom);
        while (beat <= 16 && cycles < 200) begin
            n_valid = 1;
            n_data  = DW'(beat);
            n_ready = 1'($urandom_range(0, 1));
            c_ready = n_ready;
            exp_q.push_back(n_data);
            #1;
            e = exp_q.pop_front();
            n_cmp++; if (a_cdata !== e || a_cvalid !== 1'b1 || a_cstrb !== n_strb)
                begin n_err++; $display("FAIL stream_mirror got v=%b d=%h s=%h want v=1 d=%h s=%h",
                                        a_cvalid, a_cdata, a_cstrb, e, n_strb); end
            step();
            n_cmp++; if (a_det !== m_det || a_det !== 1'b0)
                begin n_err++; $display("FAIL stream_det beat %0d got %b want 0", beat, a_det); end
            if (n_ready) begin
                beat++;
                n_strb = SW'($urandom);
            end
            cycles++;
        end
        n_cmp++; if (beat <= 16) begin n_err++; $display("FAIL stream_timeout got %0d beats want 16", beat - 1); end
        n_cmp++; if (a_cnt !== 8'd0) begin n_err++; $display("FAIL stream_cnt got %0d want 0", a_cnt); end
        idle_inputs();
    endtask

    task automatic test_ready_mismatch();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            n_ready = 1; c_ready = 0;
            step();
            n_cmp++; if (a_det !== 1'b1 || a_det !== m_det)
                begin n_err++; $display("FAIL rm_det cycle %0d got %b want 1", i, a_det); end
        end
        idle_inputs();
        step();
        n_cmp++; if (a_det !== 1'b0)    begin n_err++; $display("FAIL rm_det_end got %b want 0", a_det); end
        n_cmp++; if (a_type !== 2'b01)  begin n_err++; $display("FAIL rm_type got %b want 01", a_type); end
        n_cmp++; if (a_cnt !== 8'd3)    begin n_err++; $display("FAIL rm_cnt got %0d want 3", a_cnt); end
        n_cmp++; if (a_sticky !== 1'b1) begin n_err++; $display("FAIL rm_sticky got %b want 1", a_sticky); end
    endtask

    task automatic test_saturation();
        idle_inputs();
        clr = 1;
        step();
        clr = 0;
        n_cmp++; if (a_cnt !== 8'd0 || b_cnt !== 2'd0 || a_sticky !== 1'b0)
            begin n_err++; $display("FAIL clear got cnt=%0d/%0d sticky=%b want 0/0/0", a_cnt, b_cnt, a_sticky); end
        for (int i = 1; i <= 5; i++) begin
            n_ready = 0; c_ready = 1;
            step();
            n_cmp++; if (b_cnt !== 2'((i < 3) ? i : 3) || a_cnt !== 8'(i))
                begin n_err++; $display("FAIL sat_cnt step %0d got %0d/%0d want %0d/%0d",
                                        i, b_cnt, a_cnt, (i < 3) ? i : 3, i); end
        end
        n_ready = 0; c_ready = 1; clr = 1;
        step();
        clr = 0;
        n_cmp++; if (a_cnt !== 8'd1 || b_cnt !== 2'd1 || a_sticky !== 1'b1 || b_sticky !== 1'b1)
            begin n_err++; $display("FAIL clear_vs_fault got cnt=%0d/%0d sticky=%b/%b want 1/1/1/1",
                                    a_cnt, b_cnt, a_sticky, b_sticky); end
        idle_inputs();
        step();
    endtask

`ifdef HWPE_STREAM_COPY_SOURCE_PROTOCOL_CHECK_EN
    task automatic test_protocol();
        idle_inputs();
        clr = 1;
        step();
        clr = 0;
        n_valid = 1; n_ready = 0; c_ready = 0;
        n_data = 32'hDEAD_BEEF; n_strb = 4'hF;
        step();
        step();
        n_data = 32'hDEAD_BEEE;
        step();
        n_cmp++; if (a_det !== 1'b1 || a_type !== 2'b10 || a_cnt !== 8'd1)
            begin n_err++; $display("FAIL proto_data got det=%b type=%b cnt=%0d want 1 10 1", a_det, a_type, a_cnt); end
        step();
        n_cmp++; if (a_det !== 1'b0) begin n_err++; $display("FAIL proto_once got %b want 0", a_det); end
        n_ready = 1; c_ready = 1;
        step();
        n_cmp++; if (a_det !== 1'b0) begin n_err++; $display("FAIL proto_hs got %b want 0", a_det); end
        n_data = 32'h1234_5678; n_ready = 0; c_ready = 0;
        step();
        n_valid = 0;
        step();
        n_cmp++; if (a_det !== 1'b1 || a_type !== 2'b10 || a_cnt !== 8'd2)
            begin n_err++; $display("FAIL proto_drop got det=%b type=%b cnt=%0d want 1 10 2", a_det, a_type, a_cnt); end
        n_cmp++; if (dut.u_stall_checker.state_o !== 1'b0)
            begin n_err++; $display("FAIL proto_idle got %b want 0", dut.u_stall_checker.state_o); end
        n_valid = 1; n_ready = 1; c_ready = 1; n_data = 32'h0000_00AA;
        step();
        idle_inputs();
        step();
        n_cmp++; if (a_det !== 1'b0 || a_cnt !== 8'd2)
            begin n_err++; $display("FAIL proto_clean got det=%b cnt=%0d want 0 2", a_det, a_cnt); end
    endtask
`endif

    task automatic test_random();
        logic [23:0] got, want;
        for (int i = 0; i < 60; i++) begin
            n_valid = 1'($urandom_range(0, 1));
            n_ready = 1'($urandom_range(0, 1));
            c_ready = ($urandom_range(0, 3) == 0) ? ~n_ready : n_ready;
            n_data  = DW'($urandom_range(0, 3));
            n_strb  = SW'($urandom);
            clr     = ($urandom_range(0, 7) == 0);
            #1;
            n_cmp++; if (b_cdata !== n_data || b_cvalid !== n_valid || b_cstrb !== n_strb)
                begin n_err++; $display("FAIL rand_mirror cycle %0d got %h want %h", i, b_cdata, n_data); end
            step();
            got  = {a_det, a_type, a_sticky, a_cnt, b_det, b_type, b_sticky, b_cnt, 6'd0};
            want = {m_det, m_type, m_sticky, 8'(m_cnt), m_det, m_type, m_sticky, 2'(m_cnt_s), 6'd0};
            n_cmp++; if (got !== want)
                begin n_err++; $display("FAIL rand_flags cycle %0d got %h want %h", i, got, want); end
        end
        idle_inputs();
        step();
    endtask

    task automatic test_reset_mid_stall();
        n_valid = 1; n_ready = 0; c_ready = 0;
        n_data = DW'($urandom); n_strb = 4'hF;
        step();
        step();
        rst = 1;
        step();
        rst = 0;
        n_cmp++; if ({a_det, a_sticky, a_type, a_cnt} !== 12'd0)
            begin n_err++; $display("FAIL rst_stall got %h want 000", {a_det, a_sticky, a_type, a_cnt}); end
        n_cmp++; if ({b_det, b_sticky, b_type, b_cnt} !== 6'd0)
            begin n_err++; $display("FAIL rst_stall_sat got %b want 000000", {b_det, b_sticky, b_type, b_cnt}); end
        step();
        n_ready = 1; c_ready = 1;
        step();
        n_cmp++; if (a_det !== 1'b0) begin n_err++; $display("FAIL rst_resume_det got %b want 0", a_det); end
        idle_inputs();
        step();
        n_cmp++; if (a_det !== 1'b0 || a_cnt !== 8'd0 || a_sticky !== 1'b0)
            begin n_err++; $display("FAIL rst_resume got det=%b cnt=%0d sticky=%b want 0 0 0", a_det, a_cnt, a_sticky); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_ready_mismatch();
        test_saturation();
`ifdef HWPE_STREAM_COPY_SOURCE_PROTOCOL_CHECK_EN
        test_protocol();
`endif
        test_random();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
